// File: rtl/rx_pacotes_bitbakery.sv
// Receives the BitBakery 8E1 status stream and reassembles the 4-byte frame into game fields.
// Latency: byte_valid 1 cycle after the stop-bit sample; frame_valid 1 cycle after the sync byte's byte_valid.
// No backpressure: the serial line cannot be stalled, so every event is a single-cycle pulse.
module rx_pacotes_bitbakery #(
  parameter int BAUD_DIV = 434
) (
  input  logic       clock,
  input  logic       reset_in,
  input  logic       entrada_serial,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_valid,
  output logic [1:0] minigame,
  output logic [3:0] estado,
  output logic [6:0] jogada,
  output logic       dificuldade,
  output logic       parity_error,
  output logic       framing_error,
  output logic       sequence_error,
  output logic [3:0] db_estado
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] L_FULL = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] L_HALF = CW'(BAUD_DIV / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_PARITY    = 3'd3,
    S_STOP      = 3'd4,
    S_WAIT_IDLE = 3'd5
  } rx_state_t;

  typedef enum logic [2:0] {
    F_HUNT = 3'd0,
    F_EXP0 = 3'd1,
    F_EXP1 = 3'd2,
    F_EXP2 = 3'd3,
    F_EXP3 = 3'd4
  } frame_state_t;

  logic          r_sync1, r_sync2, r_rx_prev;
  logic          w_rx_s;
  rx_state_t     r_rx_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_par;
  logic          r_byte_valid;
  logic [7:0]    r_byte_data;
  logic          r_parity_error;
  logic          r_framing_error;

  frame_state_t  r_fstate;
  frame_state_t  w_mismatch_next;
  logic          w_is_sync;
  logic [1:0]    w_tag;
  logic [1:0]    r_sh_mg;
  logic [3:0]    r_sh_est;
  logic [6:0]    r_sh_jog;
  logic          r_sh_dif;
  logic          r_frame_valid;
  logic          r_sequence_error;
  logic [1:0]    r_minigame;
  logic [3:0]    r_estado;
  logic [6:0]    r_jogada;
  logic          r_dificuldade;

  assign w_rx_s          = r_sync2;
  assign w_tag           = r_byte_data[7:6];
  assign w_is_sync       = (r_byte_data == 8'hC0);
  // A sync byte in the wrong slot still marks a frame boundary, so it re-arms at EXP0.
  assign w_mismatch_next = w_is_sync ? F_EXP0 : F_HUNT;

  // Two-flop synchroniser plus one delayed copy for start-edge detection.
  always_ff @(posedge clock or negedge reset_in) begin
    if (!reset_in) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync1   <= entrada_serial;
      r_sync2   <= r_sync1;
      r_rx_prev <= r_sync2;
    end
  end

  // Bit-level receiver: mid-bit sampling, parity and stop checks, byte/error pulses.
  always_ff @(posedge clock or negedge reset_in) begin
    if (!reset_in) begin
      r_rx_state      <= S_IDLE;
      r_cnt           <= '0;
      r_bit_cnt       <= '0;
      r_shift         <= '0;
      r_par           <= 1'b0;
      r_byte_valid    <= 1'b0;
      r_byte_data     <= '0;
      r_parity_error  <= 1'b0;
      r_framing_error <= 1'b0;
    end else begin
      r_byte_valid    <= 1'b0;
      r_parity_error  <= 1'b0;
      r_framing_error <= 1'b0;
      case (r_rx_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (r_rx_prev && !w_rx_s) r_rx_state <= S_START;
        end
        S_START: begin
          if (r_cnt == L_HALF) begin
            r_cnt     <= '0;
            r_bit_cnt <= '0;
            // A line that is high again at mid start bit was a glitch.
            r_rx_state <= w_rx_s ? S_IDLE : S_DATA;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (r_cnt == L_FULL) begin
            r_cnt   <= '0;
            r_shift <= {w_rx_s, r_shift[7:1]};
            if (r_bit_cnt == 3'd7) r_rx_state <= S_PARITY;
            else                   r_bit_cnt  <= r_bit_cnt + 3'd1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_PARITY: begin
          if (r_cnt == L_FULL) begin
            r_cnt      <= '0;
            r_par      <= w_rx_s;
            r_rx_state <= S_STOP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_STOP: begin
          if (r_cnt == L_FULL) begin
            r_cnt <= '0;
            if (!w_rx_s) begin
              r_framing_error <= 1'b1;
              r_rx_state      <= S_WAIT_IDLE;
            end else if (^{r_shift, r_par}) begin
              r_parity_error <= 1'b1;
              r_rx_state     <= S_IDLE;
            end else begin
              r_byte_valid <= 1'b1;
              r_byte_data  <= r_shift;
              r_rx_state   <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_WAIT_IDLE: begin
          if (w_rx_s) r_rx_state <= S_IDLE;
        end
        default: r_rx_state <= S_IDLE;
      endcase
    end
  end

  // Frame tracker: checks tag order, fills shadows, publishes on the closing sync byte.
  always_ff @(posedge clock or negedge reset_in) begin
    if (!reset_in) begin
      r_fstate         <= F_HUNT;
      r_sh_mg          <= '0;
      r_sh_est         <= '0;
      r_sh_jog         <= '0;
      r_sh_dif         <= 1'b0;
      r_frame_valid    <= 1'b0;
      r_sequence_error <= 1'b0;
      r_minigame       <= '0;
      r_estado         <= '0;
      r_jogada         <= '0;
      r_dificuldade    <= 1'b0;
    end else begin
      r_frame_valid    <= 1'b0;
      r_sequence_error <= 1'b0;
      if (r_parity_error || r_framing_error) begin
        r_fstate <= F_HUNT;
        r_sh_mg  <= '0;
        r_sh_est <= '0;
        r_sh_jog <= '0;
        r_sh_dif <= 1'b0;
      end else begin
        case (r_fstate)
          F_HUNT: begin
            r_sh_mg  <= '0;
            r_sh_est <= '0;
            r_sh_jog <= '0;
            r_sh_dif <= 1'b0;
            if (r_byte_valid && w_is_sync) r_fstate <= F_EXP0;
          end
          F_EXP0: if (r_byte_valid) begin
            if (w_tag == 2'b00) begin
              r_sh_mg  <= r_byte_data[5:4];
              r_sh_est <= r_byte_data[3:0];
              r_fstate <= F_EXP1;
            end else begin
              r_sequence_error <= 1'b1;
              r_fstate         <= w_mismatch_next;
            end
          end
          F_EXP1: if (r_byte_valid) begin
            if (w_tag == 2'b01) begin
              r_sh_jog[5:0] <= r_byte_data[5:0];
              r_fstate      <= F_EXP2;
            end else begin
              r_sequence_error <= 1'b1;
              r_fstate         <= w_mismatch_next;
            end
          end
          F_EXP2: if (r_byte_valid) begin
            if (w_tag == 2'b10 && r_byte_data[3:0] == 4'b0000) begin
              r_sh_jog[6] <= r_byte_data[5];
              r_sh_dif    <= r_byte_data[4];
              r_fstate    <= F_EXP3;
            end else begin
              r_sequence_error <= 1'b1;
              r_fstate         <= w_mismatch_next;
            end
          end
          F_EXP3: if (r_byte_valid) begin
            if (w_is_sync) begin
              r_minigame    <= r_sh_mg;
              r_estado      <= r_sh_est;
              r_jogada      <= r_sh_jog;
              r_dificuldade <= r_sh_dif;
              r_frame_valid <= 1'b1;
              r_fstate      <= F_EXP0;
            end else begin
              r_sequence_error <= 1'b1;
              r_fstate         <= F_HUNT;
            end
          end
          default: r_fstate <= F_HUNT;
        endcase
      end
    end
  end

  assign byte_valid     = r_byte_valid;
  assign byte_data      = r_byte_data;
  assign parity_error   = r_parity_error;
  assign framing_error  = r_framing_error;
  assign frame_valid    = r_frame_valid;
  assign sequence_error = r_sequence_error;
  assign minigame       = r_minigame;
  assign estado         = r_estado;
  assign jogada         = r_jogada;
  assign dificuldade    = r_dificuldade;
  assign db_estado      = {r_rx_state, (r_fstate != F_HUNT)};

endmodule

// File: tb/tb_rx_pacotes_bitbakery.sv
// Bench for rx_pacotes_bitbakery: directed scenarios followed by randomized frames, junk and faults.
// Expected pulses are queued at send time and consumed by an independent monitor.
// The line is driven on falling edges; outputs are sampled on falling edges.
`timescale 1ns/1ps
module tb_rx_pacotes_bitbakery;

  localparam int BD = 16;
  localparam logic [2:0] K_BYTE = 3'd0, K_PAR = 3'd1, K_FRM = 3'd2, K_SEQ = 3'd3, K_FRAME = 3'd4;

  typedef struct packed {
    logic [2:0]  kind;
    logic [13:0] val;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ser = 1'b1;
  logic       byte_valid, frame_valid, dificuldade;
  logic       parity_error, framing_error, sequence_error;
  logic [7:0] byte_data;
  logic [1:0] minigame;
  logic [3:0] estado, db_estado;
  logic [6:0] jogada;

  ev_t q[$];
  int  n_pass = 0;
  int  n_total = 0;

  // Reference model: position within the frame (-1 = not locked), shadows, published fields.
  int          pos = -1;
  logic [1:0]  m_mg = '0;
  logic [3:0]  m_est = '0;
  logic [6:0]  m_jog = '0;
  logic        m_dif = 1'b0;
  logic [13:0] pub = '0;

  always #5 clk = ~clk;

  rx_pacotes_bitbakery #(.BAUD_DIV(BD)) dut (
    .clock(clk), .reset_in(rst_n), .entrada_serial(ser),
    .byte_valid(byte_valid), .byte_data(byte_data), .frame_valid(frame_valid),
    .minigame(minigame), .estado(estado), .jogada(jogada), .dificuldade(dificuldade),
    .parity_error(parity_error), .framing_error(framing_error),
    .sequence_error(sequence_error), .db_estado(db_estado)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push_ev(input logic [2:0] k, input logic [13:0] v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    q.push_back(e);
  endtask

  task automatic mon(input string name, input logic [2:0] k, input logic [13:0] v);
    ev_t e;
    n_total++;
    if (q.size() == 0) begin
      $display("FAIL %s: unexpected pulse val=%h, expected no event", name, v);
    end else begin
      e = q.pop_front();
      if (e.kind == k && e.val == v) n_pass++;
      else $display("FAIL %s: got kind=%0d val=%h expected kind=%0d val=%h", name, k, v, e.kind, e.val);
    end
  endtask

  // Monitor: every output pulse must match the oldest outstanding expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (byte_valid)     mon("byte", K_BYTE, {6'd0, byte_data});
      if (parity_error)   mon("parity_err", K_PAR, 14'd0);
      if (framing_error)  mon("framing_err", K_FRM, 14'd0);
      if (sequence_error) mon("sequence_err", K_SEQ, 14'd0);
      if (frame_valid)    mon("frame", K_FRAME, {minigame, estado, jogada, dificuldade});
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Frame rules applied to one correctly received byte.
  task automatic model_good(input logic [7:0] b);
    bit ok;
    push_ev(K_BYTE, {6'd0, b});
    if (pos < 0) begin
      if (b == 8'hC0) pos = 0;
    end else begin
      case (pos)
        0:       ok = (b[7:6] == 2'b00);
        1:       ok = (b[7:6] == 2'b01);
        2:       ok = (b[7:6] == 2'b10) && (b[3:0] == 4'h0);
        default: ok = (b == 8'hC0);
      endcase
      if (ok) begin
        case (pos)
          0: begin m_mg = b[5:4]; m_est = b[3:0]; end
          1: m_jog[5:0] = b[5:0];
          2: begin m_jog[6] = b[5]; m_dif = b[4]; end
          default: begin
            pub = {m_mg, m_est, m_jog, m_dif};
            push_ev(K_FRAME, pub);
          end
        endcase
        pos = (pos + 1) % 4;
      end else begin
        push_ev(K_SEQ, 14'd0);
        pos = (b == 8'hC0) ? 0 : -1;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input bit bad_par, input bit stop_bit);
    logic [10:0] f;
    if (!stop_bit) begin
      push_ev(K_FRM, 14'd0);
      pos = -1;
    end else if (bad_par) begin
      push_ev(K_PAR, 14'd0);
      pos = -1;
    end else begin
      model_good(d);
    end
    f = {stop_bit, (^d) ^ bad_par, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      ser = f[i];
      repeat (BD - 1) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [1:0] mg, input logic [3:0] est, input logic [6:0] jog,
                            input logic dif, input int gap);
    logic [7:0] b [4];
    b[0] = {2'b00, mg, est};
    b[1] = {2'b01, jog[5:0]};
    b[2] = {2'b10, jog[6], dif, 4'b0000};
    b[3] = 8'hC0;
    for (int i = 0; i < 4; i++) begin
      send_byte(b[i], 1'b0, 1'b1);
      idle(gap);
    end
  endtask

  task automatic check_idle(input string name);
    logic [3:0] exp_db;
    idle(6);
    exp_db = {3'b000, (pos >= 0)};
    chk({name, "_db_estado"}, db_estado, exp_db);
    chk({name, "_fields"}, {minigame, estado, jogada, dificuldade}, pub);
  endtask

  task automatic glitch(input int len);
    @(negedge clk);
    ser = 1'b0;
    repeat (len) @(negedge clk);
    ser = 1'b1;
    idle(3 * BD);
  endtask

  initial begin
    logic [7:0] pb;
    int r;
    // 1: reset and idle line
    idle(5);
    chk("in_reset_outputs", {byte_data, minigame, estado, jogada, dificuldade, db_estado}, 32'd0);
    rst_n = 1'b1;
    idle(200);
    chk("reset_outputs", {byte_data, minigame, estado, jogada, dificuldade, db_estado}, 32'd0);

    // 2: first complete frame
    send_byte(8'hC0, 1'b0, 1'b1);
    send_frame(2'b01, 4'b1011, 7'b1100101, 1'b0, 0);
    idle(6);
    chk("t2_minigame", minigame, 2'b01);
    chk("t2_estado", estado, 4'b1011);
    chk("t2_jogada", jogada, 7'b1100101);
    chk("t2_dificuldade", dificuldade, 1'b0);
    chk("t2_locked", db_estado, 4'b0001);

    // 3: parity fault on a sync byte
    send_byte(8'hC0, 1'b1, 1'b1);
    idle(6);
    chk("t3_unlocked", db_estado[0], 1'b0);
    chk("t3_fields_held", {minigame, estado, jogada, dificuldade}, {2'b01, 4'b1011, 7'b1100101, 1'b0});

    // 4: framing fault with line held low, then a good sync
    send_byte(8'h1B, 1'b0, 1'b0);
    idle(40);
    ser = 1'b1;
    idle(2 * BD);
    chk("t4_idle_after_framing", db_estado, 4'b0000);
    send_byte(8'hC0, 1'b0, 1'b1);
    idle(6);
    chk("t4_relock", db_estado, 4'b0001);

    // 5: out-of-order tag, then a recovering frame
    send_byte(8'h1B, 1'b0, 1'b1);
    send_byte(8'hA0, 1'b0, 1'b1);
    idle(6);
    chk("t5_hunt", db_estado, 4'b0000);
    send_byte(8'hC0, 1'b0, 1'b1);
    send_byte(8'h2F, 1'b0, 1'b1);
    send_byte(8'h40, 1'b0, 1'b1);
    send_byte(8'h80, 1'b0, 1'b1);
    send_byte(8'hC0, 1'b0, 1'b1);
    idle(6);
    chk("t5_estado", estado, 4'b1111);
    chk("t5_minigame", minigame, 2'b10);
    chk("t5_jogada", jogada, 7'b0000000);

    // 6: short glitch, then reset in the middle of a byte
    glitch(6);
    check_idle("t6_glitch");
    pb = 8'h5A;
    @(negedge clk);
    ser = 1'b0;
    repeat (BD - 1) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ser = pb[i];
      repeat (BD - 1) @(negedge clk);
    end
    @(negedge clk);
    ser = pb[4];
    idle(BD / 2);
    rst_n = 1'b0;
    idle(3);
    chk("t6_reset_outputs", {byte_data, minigame, estado, jogada, dificuldade, db_estado}, 32'd0);
    chk("t6_no_pending", q.size(), 32'd0);
    q.delete();
    pos = -1;
    pub = '0;
    ser = 1'b1;
    idle(2);
    rst_n = 1'b1;
    idle(3 * BD);
    send_byte(8'hC0, 1'b0, 1'b1);
    send_frame(2'($urandom_range(0, 3)), 4'($urandom), 7'($urandom), 1'($urandom), 0);
    check_idle("t6_after_reset");

    // Randomized mix of frames, junk bytes, faults and glitches
    for (int it = 0; it < 30; it++) begin
      r = $urandom_range(0, 9);
      if (r <= 5) begin
        send_frame(2'($urandom_range(0, 3)), 4'($urandom), 7'($urandom), 1'($urandom),
                   ($urandom_range(0, 1) != 0) ? 0 : int'($urandom_range(1, 30)));
      end else if (r == 6) begin
        send_byte(8'($urandom), 1'b0, 1'b1);
      end else if (r == 7) begin
        send_byte(8'($urandom), 1'b1, 1'b1);
      end else if (r == 8) begin
        send_byte(8'($urandom), 1'($urandom), 1'b0);
        idle($urandom_range(0, 20));
        ser = 1'b1;
        idle(2 * BD);
      end else begin
        glitch($urandom_range(1, 6));
      end
      check_idle("rand");
    end

    idle(50);
    chk("queue_drained", q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
